// File: rtl/nes_cpu_bus_pkg.sv
// Shared NES CPU bus definitions: register addresses, bus widths and the
// sprite-DMA state encoding.
package nes_cpu_bus_pkg;

    localparam int CPU_AW = 16;
    localparam int CPU_DW = 8;

    localparam logic [CPU_AW-1:0] NES_TRIG_ADDR = 16'h4014;
    localparam logic [CPU_AW-1:0] NES_OAM_ADDR  = 16'h2004;

    typedef enum logic [1:0] {
        ST_READY = 2'h0,
        ST_ALIGN = 2'h1,
        ST_READ  = 2'h2,
        ST_WRITE = 2'h3
    } sprdma_state_e;

endpackage

// File: rtl/sprdma_if.sv
// CPU-side bus bundle for the sprite DMA: snooped CPU cycle inputs and the
// DMA's own bus-master outputs.
interface sprdma_if;
    import nes_cpu_bus_pkg::*;

    logic              cpu_ce_in;
    logic [CPU_AW-1:0] cpumc_a_in;
    logic [CPU_DW-1:0] cpumc_din_in;
    logic              cpumc_r_nw_in;
    logic              active_out;
    logic [CPU_AW-1:0] cpumc_a_out;
    logic [CPU_DW-1:0] cpumc_d_out;
    logic              cpumc_r_nw_out;

    modport slave (
        input  cpu_ce_in, cpumc_a_in, cpumc_din_in, cpumc_r_nw_in,
        output active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out
    );

    modport master (
        output cpu_ce_in, cpumc_a_in, cpumc_din_in, cpumc_r_nw_in,
        input  active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out
    );
endinterface

// File: rtl/sprdma.sv
// OAM sprite DMA: on a CPU write of page P to the trigger address, copies P00-PFF
// into the PPU OAM data port. SPRDMA_ODD_ALIGN_EN adds an extra align cycle on odd triggers.
module sprdma
    import nes_cpu_bus_pkg::*;
#(
    parameter logic [CPU_AW-1:0] TRIG_ADDR = NES_TRIG_ADDR,
    parameter logic [CPU_AW-1:0] OAM_ADDR  = NES_OAM_ADDR
) (
    input  logic clk_in,
    input  logic rst_n_in,
    sprdma_if.slave bus
);

    sprdma_state_e     state_q, state_d;
    logic [7:0]        page_q,  page_d;
    logic [7:0]        idx_q,   idx_d;
    logic [CPU_DW-1:0] data_q,  data_d;
`ifdef SPRDMA_ODD_ALIGN_EN
    logic              parity_q, parity_d;
    logic              extra_q,  extra_d;
`endif

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef SPRDMA_ODD_ALIGN_EN
        parity_d = parity_q;
        extra_d  = extra_q;
`endif
        if (bus.cpu_ce_in) begin
`ifdef SPRDMA_ODD_ALIGN_EN
            parity_d = ~parity_q;
`endif
            case (state_q)
                ST_READY: begin
                    if (!bus.cpumc_r_nw_in && bus.cpumc_a_in == TRIG_ADDR) begin
                        state_d = ST_ALIGN;
                        page_d  = bus.cpumc_din_in;
                        idx_d   = 8'h00;
`ifdef SPRDMA_ODD_ALIGN_EN
                        extra_d = parity_q;
`endif
                    end
                end
                ST_ALIGN: begin
`ifdef SPRDMA_ODD_ALIGN_EN
                    // Odd-cycle trigger: burn one more align cycle before reading.
                    if (extra_q) extra_d = 1'b0;
                    else         state_d = ST_READ;
`else
                    state_d = ST_READ;
`endif
                end
                ST_READ: begin
                    data_d  = bus.cpumc_din_in;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? ST_READY : ST_READ;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_READY;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= '0;
`ifdef SPRDMA_ODD_ALIGN_EN
            parity_q <= 1'b0;
            extra_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
`ifdef SPRDMA_ODD_ALIGN_EN
            parity_q <= parity_d;
            extra_q  <= extra_d;
`endif
        end
    end

    // Bus outputs depend on registered state only, so the CPU bus mux never sees a comb loop.
    always_comb begin
        bus.active_out     = (state_q != ST_READY);
        bus.cpumc_a_out    = '0;
        bus.cpumc_d_out    = '0;
        bus.cpumc_r_nw_out = 1'b1;
        case (state_q)
            ST_READ:  bus.cpumc_a_out = {page_q, idx_q};
            ST_WRITE: begin
                bus.cpumc_a_out    = OAM_ADDR;
                bus.cpumc_d_out    = data_q;
                bus.cpumc_r_nw_out = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sprdma.sv
// Directed bench for sprdma: vector table for trigger decode and first bytes,
// then full transfers covering retrigger, async reset, ce gaps and align parity.
module tb_sprdma;
    import nes_cpu_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] cpu_din;
    int checks = 0;
    int errors = 0;
    int ce_since_rst = 0;

    sprdma_if bus();

    sprdma dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model returns ~addr[7:0] on DMA reads; otherwise the CPU drives data.
    assign bus.cpumc_din_in = (bus.active_out && bus.cpumc_r_nw_out) ? ~bus.cpumc_a_out[7:0] : cpu_din;

    typedef struct {
        bit          ce;
        logic [15:0] a;
        logic [7:0]  din;
        bit          rnw;
        bit          exp_active;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        bit          exp_rnw;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [25:0] bus_vec();
        return {bus.active_out, bus.cpumc_a_out, bus.cpumc_d_out, bus.cpumc_r_nw_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input bit act, input logic [15:0] a,
                             input logic [7:0] d, input bit rnw);
        chk(name, {6'd0, bus_vec()}, {6'd0, act, a, d, rnw});
    endtask

    task automatic set_idle();
        bus.cpumc_a_in    = 16'h0000;
        bus.cpumc_r_nw_in = 1'b1;
        cpu_din           = 8'h00;
    endtask

    task automatic step(input bit ce);
        bus.cpu_ce_in = ce;
        @(posedge clk);
        #1;
        if (ce) ce_since_rst++;
        bus.cpu_ce_in = 1'b0;
    endtask

    // One CPU cycle, optionally preceded by 1-7 idle clocks during which outputs must hold.
    task automatic adv(input bit use_gap);
        logic [25:0] snap;
        int gap;
        if (use_gap) begin
            gap  = $urandom_range(1, 7);
            snap = bus_vec();
            for (int g = 0; g < gap; g++) begin
                step(1'b0);
                chk("gap_stable", {6'd0, bus_vec()}, {6'd0, snap});
            end
        end
        step(1'b1);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check_bus("async_rst", 1'b0, 16'h0000, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        ce_since_rst = 0;
    endtask

    task automatic make_parity(input bit want);
        set_idle();
        if (ce_since_rst[0] != want) step(1'b1);
    endtask

    task automatic do_dma(input logic [7:0] page, input bit use_gap,
                          input int retrig_idx, input int abort_idx);
        int align_len;
        int n_active;
        align_len = 1;
`ifdef SPRDMA_ODD_ALIGN_EN
        if (ce_since_rst[0]) align_len = 2;
`endif
        bus.cpumc_a_in    = NES_TRIG_ADDR;
        bus.cpumc_r_nw_in = 1'b0;
        cpu_din           = page;
        step(1'b1);
        set_idle();
        n_active = 0;
        for (int k = 0; k < align_len; k++) begin
            check_bus("align", 1'b1, 16'h0000, 8'h00, 1'b1);
            adv(use_gap);
            n_active++;
        end
        for (int i = 0; i < 256; i++) begin
            check_bus("read", 1'b1, {page, 8'(i)}, 8'h00, 1'b1);
            if (i == abort_idx) begin
                async_reset();
                $display("dma page=%02h aborted by reset at idx=%02h", page, i[7:0]);
                return;
            end
            adv(use_gap);
            n_active++;
            check_bus("write", 1'b1, NES_OAM_ADDR, ~8'(i), 1'b0);
            if (i == retrig_idx) begin
                bus.cpumc_a_in    = NES_TRIG_ADDR;
                bus.cpumc_r_nw_in = 1'b0;
                cpu_din           = 8'h05;
            end
            adv(use_gap);
            set_idle();
            n_active++;
        end
        check_bus("done", 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("active_len", n_active, 32'(512 + align_len));
        $display("dma page=%02h gap=%0d retrig=%0d active_ce=%0d", page, use_gap, retrig_idx, n_active);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h4014, 8'h02, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1}; // read of trigger
        vecs[1] = '{1'b1, 16'h4015, 8'h07, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1}; // write elsewhere
        vecs[2] = '{1'b0, 16'h4014, 8'h02, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1}; // no ce
        vecs[3] = '{1'b1, 16'h4014, 8'h02, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1}; // trigger -> align
        vecs[4] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0200, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0200, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h2004, 8'hFF, 1'b0};
        vecs[8] = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0201, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h2004, 8'hFE, 1'b0};

        rst_n = 1'b0;
        bus.cpu_ce_in = 1'b0;
        set_idle();
        #23;
        check_bus("reset", 1'b0, 16'h0000, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus.cpumc_a_in    = vecs[i].a;
            bus.cpumc_r_nw_in = vecs[i].rnw;
            cpu_din           = vecs[i].din;
            step(vecs[i].ce);
            check_bus($sformatf("vec%0d", i), vecs[i].exp_active, vecs[i].exp_a,
                      vecs[i].exp_d, vecs[i].exp_rnw);
            $display("vec%0d ce=%0d a=%04h rnw=%0d -> act=%0d a=%04h d=%02h rnw=%0d", i,
                     vecs[i].ce, vecs[i].a, vecs[i].rnw, bus.active_out, bus.cpumc_a_out,
                     bus.cpumc_d_out, bus.cpumc_r_nw_out);
        end
        set_idle();
        async_reset();

        do_dma(8'h02, 1'b0, -1, -1);
        do_dma(8'h02, 1'b0, 16, -1);
        do_dma(8'h02, 1'b0, -1, 64);
        do_dma(8'h03, 1'b0, -1, -1);
        do_dma(8'h02, 1'b1, -1, -1);
        make_parity(1'b1);
        do_dma(8'h11, 1'b0, -1, -1);
        make_parity(1'b0);
        do_dma(8'h12, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
